if_stage_pipe: RTL and testbench
================================

Name: if_stage_pipe

Overview:
- Parametrised next-generation instruction-fetch stage.
- Holds the fetch PC and selects between sequential, branch and jump targets.
- Talks to a variable-latency instruction memory over a req/ready handshake.
- Drives the IF/ID pipeline register, with stall, flush and a one-entry skid buffer. Sits between the PC-redirect logic in EX/MEM and the ID stage.

Parameters:
- XLEN, 32, width of PC, addresses and instruction word.
- RESET_PC, 32'h0000_0000, fetch PC after reset.
- PC_STEP, 4, byte increment per sequential fetch.
- NOP_INST, 32'h0000_0000, instruction word driven on inst_id when IF/ID holds a bubble.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_id  in  1  hazard unit: hold IF/ID.
- branch_or_pc  in  1  taken-branch redirect pulse.
- Jump  in  1  jump redirect pulse.
- branch_addr  in  XLEN  branch target.
- jump_addr  in  XLEN  jump target.
- imem_req  out  1  memory request.
- imem_addr  out  XLEN  request byte address.
- imem_ready  in  1  response valid this cycle.
- imem_rdata  in  XLEN  instruction, valid when imem_ready.
- pc  out  XLEN  current fetch PC.
- pc_id  out  XLEN  IF/ID: PC of inst_id.
- next_pc_id  out  XLEN  IF/ID: pc_id + PC_STEP.
- inst_id  out  XLEN  IF/ID instruction.
- valid_id  out  1  IF/ID holds a real instruction.

Behaviour:
- Clock and reset: single clock clk. rst is synchronous, active-high, and overrides everything.
- Reset values: pc=RESET_PC; imem_req=0; imem_addr=RESET_PC; pc_id=0; next_pc_id=0; inst_id=NOP_INST; valid_id=0; skid empty; FSM=S_REQ.
- Reset mid-request abandons the outstanding request; the memory is reset by the same rst.
- Redirect priority: branch_or_pc > Jump > sequential. Target = branch_addr / jump_addr; sequential = pc+PC_STEP, modulo 2^XLEN, wrapping silently.
- Handshake: once imem_req=1, imem_req and imem_addr stay stable until the cycle imem_ready=1. Response data is sampled in that cycle. Zero-wait memory (ready in the same cycle as req) gives 1 fetch/cycle.
- New request start: at the first cycle after rst, or in the cycle after a response, only when the skid is empty, or when the skid drains that same cycle.
- FSM states: S_REQ (request addr=pc) and S_DROP (request killed by redirect, awaiting its ready).
- S_REQ, no redirect, ready: response is accepted; pc <= pc+PC_STEP.
- S_REQ, redirect, ready: response discarded; pc <= target; stay in S_REQ.
- S_REQ, redirect, no ready: pc <= target; go to S_DROP. imem_addr keeps the old address.
- S_DROP, ready: response discarded; go to S_REQ, which issues at the new pc next cycle.
- S_DROP, redirect again: pc <= newest target; stay in S_DROP.
- IF/ID on redirect: flush regardless of stall_id. valid_id<=0, inst_id<=NOP_INST, skid cleared. Flush beats stall.
- IF/ID, no redirect, stall_id=0, skid full: load from skid.
- IF/ID, no redirect, stall_id=0, skid empty, response accepted: load the response (pc_id = request addr).
- IF/ID, no redirect, stall_id=0, otherwise: bubble (valid_id<=0, inst_id<=NOP_INST).
- IF/ID, no redirect, stall_id=1: IF/ID holds. An accepted response goes to the skid (skid must be empty; guaranteed by the issue rule).
- Skid drain: a skid draining while a response arrives in the same cycle is impossible, because no request is outstanding while the skid is full.
- Latency: zero-wait memory delivers the response in the cycle req is issued, so the instruction reaches valid_id on the next edge.

Test Plan:
- Zero-wait memory returning addr-derived data, stall_id=0, RESET_PC=0 -> imem_addr 0,4,8,... every cycle; valid_id=1 from cycle 2 with pc_id 0,4,8; next_pc_id = pc_id+4.
- Memory with 3-cycle ready; Jump=1 with jump_addr=0x40 in the 2nd wait cycle -> imem_addr held at old address until ready; that response never reaches IF/ID; next request imem_addr=0x40; valid_id=0 during the drop.
- branch_or_pc=1 and Jump=1 in the same cycle, branch_addr=0x100, jump_addr=0x200 -> next imem_addr=0x100; IF/ID flushed to NOP_INST.
- stall_id=1 for 4 cycles under zero-wait memory -> IF/ID constant; one response held in skid; imem_req=0 while skid full. On release, IF/ID shows the skid instruction, then sequential fetch with no gap or duplicate.
- stall_id=1 and branch_or_pc=1 in the same cycle -> valid_id=0 next cycle; skid cleared; fetch resumes at branch_addr.
- rst asserted for 1 cycle mid-request at pc=0x20 -> next cycle pc=RESET_PC, valid_id=0, imem_req=0; first request is to RESET_PC.

Source files
------------

// File: rtl/if_stage_pipe.sv
// Instruction-fetch stage: fetch PC, redirect selection, req/ready memory port,
// and an IF/ID register with stall, flush and a one-entry skid buffer.
module if_stage_pipe #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              PC_STEP  = 4,
  parameter logic [XLEN-1:0] NOP_INST = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_id,
  input  logic            branch_or_pc,
  input  logic            Jump,
  input  logic [XLEN-1:0] branch_addr,
  input  logic [XLEN-1:0] jump_addr,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_id,
  output logic [XLEN-1:0] next_pc_id,
  output logic [XLEN-1:0] inst_id,
  output logic            valid_id
);

  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  typedef enum logic {S_REQ = 1'b0, S_DROP = 1'b1} state_t;

  state_t          state_r, state_next_s;
  logic            redirect_s, accept_s, waiting_s;
  logic [XLEN-1:0] target_s, pc_next_s, addr_next_s;
  logic            req_next_s, skid_valid_next_s;
  logic            skid_valid_r;
  logic [XLEN-1:0] skid_inst_r, skid_pc_r;

  assign redirect_s = branch_or_pc | Jump;
  assign target_s   = branch_or_pc ? branch_addr : jump_addr;
  assign waiting_s  = imem_req & ~imem_ready;
  assign accept_s   = imem_req & imem_ready & (state_r == S_REQ) & ~redirect_s;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_r <= S_REQ;
    else     state_r <= state_next_s;
  end

  // FSM next state: a redirect while the request is still pending kills it
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_REQ: begin
        if (waiting_s && redirect_s) state_next_s = S_DROP;
        else                         state_next_s = S_REQ;
      end
      S_DROP: begin
        if (imem_ready) state_next_s = S_REQ;
        else            state_next_s = S_DROP;
      end
      default: state_next_s = S_REQ;
    endcase
  end

  // Next PC, skid occupancy and the next request; a new request is issued only
  // when nothing is pending and the skid will be empty after this cycle
  always_comb begin
    pc_next_s         = pc;
    skid_valid_next_s = skid_valid_r;
    req_next_s        = imem_req;
    addr_next_s       = imem_addr;
    if (redirect_s)    pc_next_s = target_s;
    else if (accept_s) pc_next_s = pc + STEP;
    else               pc_next_s = pc;
    if (redirect_s)             skid_valid_next_s = 1'b0;
    else if (!stall_id)         skid_valid_next_s = 1'b0;
    else if (accept_s)          skid_valid_next_s = 1'b1;
    else                        skid_valid_next_s = skid_valid_r;
    if (waiting_s) begin
      req_next_s  = 1'b1;
      addr_next_s = imem_addr;
    end else if (!skid_valid_next_s) begin
      req_next_s  = 1'b1;
      addr_next_s = pc_next_s;
    end else begin
      req_next_s  = 1'b0;
      addr_next_s = imem_addr;
    end
  end

  // PC, memory request and skid registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      imem_req     <= 1'b0;
      imem_addr    <= RESET_PC;
      skid_valid_r <= 1'b0;
      skid_inst_r  <= NOP_INST;
      skid_pc_r    <= {XLEN{1'b0}};
    end else begin
      pc           <= pc_next_s;
      imem_req     <= req_next_s;
      imem_addr    <= addr_next_s;
      skid_valid_r <= skid_valid_next_s;
      if (stall_id && accept_s) begin
        skid_inst_r <= imem_rdata;
        skid_pc_r   <= imem_addr;
      end
    end
  end

  // IF/ID register: flush beats stall; skid content drains before new responses
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_id      <= {XLEN{1'b0}};
      next_pc_id <= {XLEN{1'b0}};
      inst_id    <= NOP_INST;
      valid_id   <= 1'b0;
    end else if (redirect_s) begin
      inst_id  <= NOP_INST;
      valid_id <= 1'b0;
    end else if (!stall_id) begin
      if (skid_valid_r) begin
        pc_id      <= skid_pc_r;
        next_pc_id <= skid_pc_r + STEP;
        inst_id    <= skid_inst_r;
        valid_id   <= 1'b1;
      end else if (accept_s) begin
        pc_id      <= imem_addr;
        next_pc_id <= imem_addr + STEP;
        inst_id    <= imem_rdata;
        valid_id   <= 1'b1;
      end else begin
        inst_id  <= NOP_INST;
        valid_id <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_stage_pipe.sv
// Bench for if_stage_pipe: variable-latency memory model, directed phases and a
// scoreboard of expected IF/ID instructions checked by a forked monitor.
module tb_if_stage_pipe;

  logic        clk = 1'b0;
  logic        rst, stall_id, branch_or_pc, Jump;
  logic [31:0] branch_addr, jump_addr;
  logic        imem_req, imem_ready, valid_id;
  logic [31:0] imem_addr, imem_rdata, pc, pc_id, next_pc_id, inst_id;

  int          checks = 0;
  int          failures = 0;
  int unsigned mem_lat = 0;
  int unsigned wait_cnt = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  if_stage_pipe dut (
    .clk(clk), .rst(rst), .stall_id(stall_id), .branch_or_pc(branch_or_pc),
    .Jump(Jump), .branch_addr(branch_addr), .jump_addr(jump_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .pc(pc), .pc_id(pc_id), .next_pc_id(next_pc_id),
    .inst_id(inst_id), .valid_id(valid_id)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  // Memory answers after mem_lat wait cycles; mem_lat=0 is zero-wait.
  always @(posedge clk) begin
    if (rst)                         wait_cnt <= 0;
    else if (imem_req && imem_ready) wait_cnt <= 0;
    else if (imem_req)               wait_cnt <= wait_cnt + 1;
  end
  assign imem_ready = imem_req && (wait_cnt >= mem_lat);
  assign imem_rdata = inst_of(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int unsigned lat);
    rst = 1'b1; stall_id = 1'b0; branch_or_pc = 1'b0; Jump = 1'b0;
    mem_lat = lat;
    step();
    rst = 1'b0;
  endtask

  // Pops one expected PC each time IF/ID is freshly loaded with a valid instruction.
  task automatic monitor();
    logic        st, r;
    logic [31:0] e;
    forever begin
      @(posedge clk);
      st = stall_id;
      r  = rst;
      @(negedge clk);
      if (!r && !st && valid_id) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow_pc", pc_id, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc_id", pc_id, e);
          chk("sb_inst_id", inst_id, inst_of(e));
          chk("sb_next_pc_id", next_pc_id, e + 32'd4);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; stall_id = 1'b0; branch_or_pc = 1'b0; Jump = 1'b0;
    branch_addr = 32'h0; jump_addr = 32'h0;
    fork monitor(); join_none

    // Reset values and zero-wait streaming
    do_reset(0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, valid_id}, 32'h0);
    chk("rst_inst", inst_id, 32'h0);
    chk("rst_pc_id", pc_id, 32'h0);
    chk("rst_next_pc_id", next_pc_id, 32'h0);
    for (int i = 0; i < 7; i++) exp_q.push_back(32'(4 * i));
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("stream_req", {31'b0, imem_req}, 32'h1);
      chk("stream_addr", imem_addr, 32'(4 * (i - 1)));
    end

    // 3-cycle memory, jump during the second wait cycle
    do_reset(2);
    exp_q.push_back(32'h40);
    step();
    step();
    Jump = 1'b1; jump_addr = 32'h40;
    step();
    Jump = 1'b0;
    chk("drop_addr_held", imem_addr, 32'h0);
    chk("drop_req_held", {31'b0, imem_req}, 32'h1);
    chk("drop_valid", {31'b0, valid_id}, 32'h0);
    step();
    chk("drop_new_addr", imem_addr, 32'h40);
    chk("drop_valid2", {31'b0, valid_id}, 32'h0);
    for (int i = 0; i < 4; i++) step();

    // Branch beats jump; then a jump that wraps the PC
    do_reset(0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    step();
    step();
    branch_or_pc = 1'b1; Jump = 1'b1; branch_addr = 32'h100; jump_addr = 32'h200;
    step();
    branch_or_pc = 1'b0; Jump = 1'b0;
    chk("prio_addr", imem_addr, 32'h100);
    chk("prio_flush_valid", {31'b0, valid_id}, 32'h0);
    chk("prio_flush_inst", inst_id, 32'h0);
    step();
    Jump = 1'b1; jump_addr = 32'hFFFF_FFFC;
    step();
    Jump = 1'b0;
    chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_addr_zero", imem_addr, 32'h0);
    step();
    step();

    // Four-cycle stall fills the skid, then drains without gap or duplicate
    do_reset(0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);
    step();
    step();
    stall_id = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_req_off", {31'b0, imem_req}, 32'h0);
      chk("stall_pc_id_hold", pc_id, 32'h0);
      chk("stall_valid_hold", {31'b0, valid_id}, 32'h1);
    end
    stall_id = 1'b0;
    step();
    chk("skid_drain_pc_id", pc_id, 32'h4);
    chk("skid_drain_req", {31'b0, imem_req}, 32'h1);
    chk("skid_drain_addr", imem_addr, 32'h8);
    step();
    step();

    // Stall and branch together: flush wins, skid content is dropped
    do_reset(0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h80);
    exp_q.push_back(32'h84);
    step();
    step();
    stall_id = 1'b1;
    step();
    branch_or_pc = 1'b1; branch_addr = 32'h80;
    step();
    stall_id = 1'b0; branch_or_pc = 1'b0;
    chk("stallflush_valid", {31'b0, valid_id}, 32'h0);
    chk("stallflush_inst", inst_id, 32'h0);
    chk("stallflush_req", {31'b0, imem_req}, 32'h1);
    chk("stallflush_addr", imem_addr, 32'h80);
    step();
    step();

    // Reset while a request to 0x20 is outstanding
    do_reset(2);
    step();
    Jump = 1'b1; jump_addr = 32'h20;
    step();
    Jump = 1'b0;
    chk("mid_pc_redirected", pc, 32'h20);
    step();
    step();
    chk("mid_pc", pc, 32'h20);
    chk("mid_addr", imem_addr, 32'h20);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_valid", {31'b0, valid_id}, 32'h0);
    chk("mid_rst_req", {31'b0, imem_req}, 32'h0);
    step();
    chk("mid_first_req", {31'b0, imem_req}, 32'h1);
    chk("mid_first_addr", imem_addr, 32'h0);
    step();
    step();

    chk("sb_leftover", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
